// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the initiator's state encoding.
package axi_lite_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WRITE_AW_W,
        WRITE_RESP,
        READ_AR,
        READ_RESP
    } state_t;
endpackage

// File: rtl/axi_lite_initiator_sticky_bit.sv
// Set-and-hold flag: remembers that a channel handshake has happened until cleared.
module sticky_bit (
    input  logic axi_clk,
    input  logic axi_reset,
    input  logic set,
    input  logic clr,
    output logic q
);
    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset)  q <= 1'b0;
        else if (clr)   q <= 1'b0;
        else if (set)   q <= 1'b1;
    end
endmodule

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI-Lite initiator: turns a req/ready user strobe into one
// AXI-Lite write or read and reports the response with a one-cycle done pulse.
module axi_lite_initiator
    import axi_lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 16
) (
    input  logic                        axi_clk,
    input  logic                        axi_reset,
    input  logic                        req,
    output logic                        ready,
    input  logic                        write_enable,
    input  logic [AXI_ADDR_WIDTH-1:0]   addr,
    input  logic [AXI_DATA_WIDTH-1:0]   write_data,
    output logic                        write_done,
    output logic [AXI_DATA_WIDTH-1:0]   read_data,
    output logic                        read_data_valid,
    output logic [1:0]                  resp,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
    output logic                        axi_awvalid,
    input  logic                        axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                        axi_wvalid,
    input  logic                        axi_wready,
    input  logic [1:0]                  axi_bresp,
    input  logic                        axi_bvalid,
    output logic                        axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
    output logic                        axi_arvalid,
    input  logic                        axi_arready,
    input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
    input  logic [1:0]                  axi_rresp,
    input  logic                        axi_rvalid,
    output logic                        axi_rready
);
    state_t                    state;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic                      aw_flag, w_flag;
    logic                      aw_hs, w_hs, aw_done, w_done, flag_clr;

    assign ready      = (state == IDLE);
    assign axi_awaddr = addr_q;
    assign axi_araddr = addr_q;
    assign axi_wdata  = wdata_q;
    assign axi_wstrb  = '1;

    assign aw_hs    = axi_awvalid && axi_awready;
    assign w_hs     = axi_wvalid && axi_wready;
    assign flag_clr = (state != WRITE_AW_W);
    // A channel counts as done if it handshook earlier or is handshaking now.
    assign aw_done  = aw_flag || aw_hs;
    assign w_done   = w_flag || w_hs;

    sticky_bit u_aw_done (.axi_clk(axi_clk), .axi_reset(axi_reset), .set(aw_hs), .clr(flag_clr), .q(aw_flag));
    sticky_bit u_w_done  (.axi_clk(axi_clk), .axi_reset(axi_reset), .set(w_hs),  .clr(flag_clr), .q(w_flag));

    always_ff @(posedge axi_clk or posedge axi_reset) begin
        if (axi_reset) begin
            state           <= IDLE;
            addr_q          <= '0;
            wdata_q         <= '0;
            axi_awvalid     <= 1'b0;
            axi_wvalid      <= 1'b0;
            axi_bready      <= 1'b0;
            axi_arvalid     <= 1'b0;
            axi_rready      <= 1'b0;
            write_done      <= 1'b0;
            read_data_valid <= 1'b0;
            read_data       <= '0;
            resp            <= RESP_OKAY;
        end else begin
            write_done      <= 1'b0;
            read_data_valid <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    addr_q  <= addr;
                    wdata_q <= write_data;
                    if (write_enable) begin
                        state       <= WRITE_AW_W;
                        axi_awvalid <= 1'b1;
                        axi_wvalid  <= 1'b1;
                    end else begin
                        state       <= READ_AR;
                        axi_arvalid <= 1'b1;
                    end
                end
                WRITE_AW_W: begin
                    if (aw_hs) axi_awvalid <= 1'b0;
                    if (w_hs)  axi_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        state      <= WRITE_RESP;
                        axi_bready <= 1'b1;
                    end
                end
                WRITE_RESP: if (axi_bvalid && axi_bready) begin
                    resp       <= axi_bresp;
                    write_done <= 1'b1;
                    axi_bready <= 1'b0;
                    state      <= IDLE;
                end
                READ_AR: if (axi_arvalid && axi_arready) begin
                    axi_arvalid <= 1'b0;
                    axi_rready  <= 1'b1;
                    state       <= READ_RESP;
                end
                READ_RESP: if (axi_rvalid && axi_rready) begin
                    read_data       <= axi_rdata;
                    resp            <= axi_rresp;
                    read_data_valid <= 1'b1;
                    axi_rready      <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_initiator.sv
// Directed bench: transaction-level model plus per-cycle compare, with a
// configurable-latency responder and a few literal checks.
module tb_axi_lite_initiator;
    import axi_lite_pkg::*;

    logic        axi_clk = 1'b0, axi_reset = 1'b0;
    logic        req = 1'b0, write_enable = 1'b0;
    logic [19:0] addr = '0;
    logic [15:0] write_data = '0;
    logic        ready, write_done, read_data_valid;
    logic [15:0] read_data;
    logic [1:0]  resp;
    logic [19:0] axi_awaddr, axi_araddr;
    logic        axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready;
    logic [15:0] axi_wdata;
    logic [1:0]  axi_wstrb;
    logic        axi_awready = 1'b0, axi_wready = 1'b0, axi_bvalid = 1'b0;
    logic        axi_arready = 1'b0, axi_rvalid = 1'b0;
    logic [1:0]  axi_bresp = '0, axi_rresp = '0;
    logic [15:0] axi_rdata = '0;

    axi_lite_initiator #(.AXI_ADDR_WIDTH(20), .AXI_DATA_WIDTH(16)) dut (
        .axi_clk(axi_clk), .axi_reset(axi_reset), .req(req), .ready(ready),
        .write_enable(write_enable), .addr(addr), .write_data(write_data),
        .write_done(write_done), .read_data(read_data), .read_data_valid(read_data_valid),
        .resp(resp), .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
    );

    always #5 axi_clk = ~axi_clk;

    int n_tests = 0, n_fail = 0, n_wd = 0, n_rv = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Responder latencies and response payloads, set per test.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    int          aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic [1:0]  cfg_bresp = RESP_OKAY, cfg_rresp = RESP_OKAY;
    logic [15:0] cfg_rdata = '0;

    // Transaction model: one request in flight, phases tracked as seen-flags.
    logic        m_busy = 0, m_kw = 0, m_aw = 0, m_w = 0, m_ar = 0, m_wd = 0, m_rv = 0;
    logic [19:0] m_addr = '0;
    logic [15:0] m_data = '0, m_rdata = '0;
    logic [1:0]  m_resp = '0;

    always @(posedge axi_clk) begin
        m_wd = 0;
        m_rv = 0;
        if (axi_reset) begin
            m_busy = 0; m_aw = 0; m_w = 0; m_ar = 0; m_resp = '0; m_rdata = '0;
        end else if (m_busy && m_kw) begin
            if (m_aw && m_w && axi_bvalid) begin
                m_wd = 1; m_resp = axi_bresp; m_busy = 0;
            end else begin
                if (!m_aw && axi_awready) m_aw = 1;
                if (!m_w && axi_wready)   m_w = 1;
            end
        end else if (m_busy) begin
            if (m_ar && axi_rvalid) begin
                m_rv = 1; m_resp = axi_rresp; m_rdata = axi_rdata; m_busy = 0;
            end else if (!m_ar && axi_arready) m_ar = 1;
        end else if (req) begin
            m_busy = 1; m_kw = write_enable; m_addr = addr; m_data = write_data;
            m_aw = 0; m_w = 0; m_ar = 0;
        end
    end

    // Compare against the model, then let the responder react to the bus.
    always @(negedge axi_clk) begin
        logic e_aw, e_w, e_ar;
        e_aw = m_busy && m_kw && !m_aw;
        e_w  = m_busy && m_kw && !m_w;
        e_ar = m_busy && !m_kw && !m_ar;
        if (!axi_reset) begin
            chk("ready", ready, !m_busy);
            chk("awvalid", axi_awvalid, e_aw);
            chk("wvalid", axi_wvalid, e_w);
            chk("bready", axi_bready, m_busy && m_kw && m_aw && m_w);
            chk("arvalid", axi_arvalid, e_ar);
            chk("rready", axi_rready, m_busy && !m_kw && m_ar);
            chk("write_done", write_done, m_wd);
            chk("read_data_valid", read_data_valid, m_rv);
            chk("resp", resp, m_resp);
            chk("read_data", read_data, m_rdata);
            if (e_aw) chk("awaddr", axi_awaddr, m_addr);
            if (e_w) begin
                chk("wdata", axi_wdata, m_data);
                chk("wstrb", axi_wstrb, 2'b11);
            end
            if (e_ar) chk("araddr", axi_araddr, m_addr);
            if (write_done) n_wd++;
            if (read_data_valid) n_rv++;
        end
        if (axi_awvalid) begin axi_awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin axi_awready = 0; aw_cnt = 0; end
        if (axi_wvalid) begin axi_wready = (w_cnt >= w_dly); w_cnt++; end
        else begin axi_wready = 0; w_cnt = 0; end
        if (axi_arvalid) begin axi_arready = (ar_cnt >= ar_dly); ar_cnt++; end
        else begin axi_arready = 0; ar_cnt = 0; end
        if (m_busy && m_kw && m_aw && m_w) begin axi_bvalid = (b_cnt >= b_dly); b_cnt++; end
        else begin axi_bvalid = 0; b_cnt = 0; end
        axi_bresp = cfg_bresp;
        if (m_busy && !m_kw && m_ar) begin axi_rvalid = (r_cnt >= r_dly); r_cnt++; end
        else begin axi_rvalid = 0; r_cnt = 0; end
        axi_rresp = cfg_rresp;
        axi_rdata = axi_rvalid ? cfg_rdata : 16'h0000;
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            if (!m_busy) return;
            @(negedge axi_clk);
        end
        chk({name, "_timeout"}, 1, 0);
    endtask

    task automatic do_txn(input logic we, input logic [19:0] a, input logic [15:0] d, input string name);
        @(negedge axi_clk);
        req = 1; write_enable = we; addr = a; write_data = d;
        @(negedge axi_clk);
        req = 0;
        wait_idle(name);
        #2;
    endtask

    initial begin
        int wd0, rv0;
        #1 axi_reset = 1;
        #20;
        chk("rst_ready", ready, 1);
        chk("rst_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 0);
        chk("rst_pulses", {write_done, read_data_valid}, 0);
        chk("rst_read_data", read_data, 0);
        chk("rst_resp", resp, 0);
        @(negedge axi_clk); #1 axi_reset = 0;

        // Plain write, responder ready immediately.
        do_txn(1, 20'h00012, 16'hBEEF, "write");
        chk("write_count", n_wd, 1);
        chk("write_resp", resp, 2'b00);

        // Skewed write: W accepted 3 cycles before AW.
        aw_dly = 3;
        do_txn(1, 20'h00034, 16'h1357, "skew");
        chk("skew_count", n_wd, 2);
        aw_dly = 0;

        // Read with data two cycles after AR.
        r_dly = 2; cfg_rdata = 16'hBEEF;
        do_txn(0, 20'h00012, 16'h0000, "read");
        chk("read_count", n_rv, 1);
        chk("read_value", read_data, 16'hBEEF);
        chk("read_resp", resp, 2'b00);

        // Error write response reported unchanged.
        cfg_bresp = RESP_SLVERR;
        do_txn(1, 20'hFFFFE, 16'h0001, "slverr");
        chk("slverr_resp", resp, 2'b10);
        chk("slverr_count", n_wd, 3);
        chk("slverr_ready", ready, 1);
        chk("slverr_read_data_held", read_data, 16'hBEEF);
        cfg_bresp = RESP_OKAY;

        // Error read response with data.
        cfg_rresp = RESP_DECERR; cfg_rdata = 16'h0F0F; r_dly = 0;
        do_txn(0, 20'h80000, 16'h0000, "decerr");
        chk("decerr_resp", resp, 2'b11);
        chk("decerr_data", read_data, 16'h0F0F);
        cfg_rresp = RESP_OKAY;

        // Reset while waiting for the write response.
        b_dly = 6; wd0 = n_wd;
        @(negedge axi_clk);
        req = 1; write_enable = 1; addr = 20'h00044; write_data = 16'h4444;
        @(negedge axi_clk);
        req = 0;
        for (int i = 0; i < 50 && !(m_busy && m_aw && m_w); i++) @(negedge axi_clk);
        chk("rst_mid_reached_resp", m_busy && m_aw && m_w, 1);
        @(negedge axi_clk);
        #2 axi_reset = 1;
        #1;
        chk("rst_mid_valids", {axi_awvalid, axi_wvalid, axi_bready, axi_arvalid, axi_rready}, 0);
        chk("rst_mid_ready", ready, 1);
        chk("rst_mid_done", write_done, 0);
        @(negedge axi_clk); #1 axi_reset = 0;
        repeat (4) @(negedge axi_clk);
        #2;
        chk("rst_mid_no_done", n_wd, wd0);
        chk("rst_mid_resp", resp, 0);
        b_dly = 0;

        // Back-to-back: req held high, read reissued in the write_done cycle;
        // the changed inputs while busy must be ignored by the write.
        wd0 = n_wd; rv0 = n_rv; r_dly = 1; cfg_rdata = 16'h1234;
        @(negedge axi_clk);
        req = 1; write_enable = 1; addr = 20'h00100; write_data = 16'hA5A5;
        @(negedge axi_clk);
        write_enable = 0; addr = 20'h00200; write_data = 16'hFFFF;
        for (int i = 0; i < 50 && !(m_busy && !m_kw); i++) @(negedge axi_clk);
        chk("b2b_read_started", m_busy && !m_kw, 1);
        chk("b2b_write_first", n_wd, wd0 + 1);
        req = 0;
        wait_idle("b2b");
        #2;
        chk("b2b_read_count", n_rv, rv0 + 1);
        chk("b2b_read_value", read_data, 16'h1234);
        repeat (3) @(negedge axi_clk);
        #2;
        chk("b2b_no_extra", n_wd + n_rv, wd0 + rv0 + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
